// File: rtl/vector_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : vector_exec_unit_if
// Brief    : Control handshake, memory port and register-file view of the
//            vector execution unit.
// Revision : 1.0
// ============================================================================
interface vector_exec_unit_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int NVREG  = 4,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    logic                            start;
    logic [1:0]                      op;
    logic [$clog2(NVREG)-1:0]        vd;
    logic [$clog2(NVREG)-1:0]        vs;
    logic [ADDR_W-1:0]               base_addr;
    logic                            busy;
    logic                            done;
    logic [ADDR_W-1:0]               mem_addr;
    logic                            mem_rd;
    logic                            mem_wr;
    logic [DATA_W-1:0]               mem_wdata;
    logic [DATA_W-1:0]               mem_rdata;
    logic [CNT_W-1:0]                cycle_count;
    logic [NVREG*LANES*DATA_W-1:0]   vreg_flat;

    modport master (
        output start, op, vd, vs, base_addr, mem_rdata,
        input  busy, done, mem_addr, mem_rd, mem_wr, mem_wdata, cycle_count, vreg_flat
    );

    modport slave (
        input  start, op, vd, vs, base_addr, mem_rdata,
        output busy, done, mem_addr, mem_rd, mem_wr, mem_wdata, cycle_count, vreg_flat
    );
endinterface
`default_nettype wire

// File: rtl/vector_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : vector_exec_unit
// Brief    : Multicycle vector load/store/add engine with a private register
//            file, one memory lane per cycle.
// Revision : 1.0
// ============================================================================
module vector_exec_unit #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int NVREG  = 4,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    vector_exec_unit_if.slave bus
);
    localparam int c_reg_w  = $clog2(NVREG);
    localparam int c_idx_w  = $clog2(LANES + 1);
    localparam int c_lane_w = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_STORE = 3'd2,
        S_ADD   = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [DATA_W-1:0]           r_vreg [NVREG][LANES];
    logic [DATA_W-1:0]           r_tmp  [LANES];
    logic [DATA_W-1:0]           w_res  [LANES];
    logic [c_reg_w-1:0]          r_vd;
    logic [c_reg_w-1:0]          r_vs;
    logic [ADDR_W-1:0]           r_base;
    logic [c_idx_w-1:0]          r_idx;
    logic [c_idx_w-1:0]          w_idx_m1;
    logic [c_lane_w-1:0]         w_lane;
    logic [c_lane_w-1:0]         w_prev_lane;
    logic                        r_sat;
    logic [CNT_W-1:0]            r_count;
    logic [NVREG*LANES*DATA_W-1:0] w_flat;

    assign w_idx_m1    = r_idx - c_idx_w'(1);
    assign w_lane      = r_idx[c_lane_w-1:0];
    assign w_prev_lane = w_idx_m1[c_lane_w-1:0];

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [DATA_W:0] w_sum;
            assign w_sum    = {1'b0, r_vreg[r_vd][i]} + {1'b0, r_vreg[r_vs][i]};
            assign w_res[i] = (r_sat && w_sum[DATA_W]) ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
        end
    endgenerate

    always_comb begin
        w_flat = '0;
        for (int r = 0; r < NVREG; r++) begin
            for (int i = 0; i < LANES; i++) begin
                w_flat[(r*LANES+i)*DATA_W +: DATA_W] = r_vreg[r][i];
            end
        end
    end

    assign bus.vreg_flat   = w_flat;
    assign bus.cycle_count = r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Memory strobes decode straight from state so reset kills them without a clock edge.
    always_comb begin
        w_next        = r_state;
        bus.busy      = (r_state != S_IDLE);
        bus.done      = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        2'b00:   w_next = S_LOAD;
                        2'b01:   w_next = S_STORE;
                        default: w_next = S_ADD;
                    endcase
                end
            end
            S_LOAD: begin
                if (r_idx < c_idx_w'(LANES)) begin
                    bus.mem_rd   = 1'b1;
                    bus.mem_addr = r_base + ADDR_W'(r_idx);
                end else begin
                    w_next = S_WB;
                end
            end
            S_STORE: begin
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = r_base + ADDR_W'(r_idx);
                bus.mem_wdata = r_vreg[r_vs][w_lane];
                if (r_idx == c_idx_w'(LANES - 1)) begin
                    w_next = S_DONE;
                end
            end
            S_ADD:   w_next = S_WB;
            S_WB:    w_next = S_DONE;
            S_DONE: begin
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vd    <= '0;
            r_vs    <= '0;
            r_base  <= '0;
            r_idx   <= '0;
            r_sat   <= 1'b0;
            r_count <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_tmp[i] <= '0;
            end
            for (int r = 0; r < NVREG; r++) begin
                for (int i = 0; i < LANES; i++) begin
                    r_vreg[r][i] <= '0;
                end
            end
        end else begin
            if (r_state == S_IDLE) begin
                if (bus.start) begin
                    r_vd    <= bus.vd;
                    r_vs    <= bus.vs;
                    r_base  <= bus.base_addr;
                    r_sat   <= bus.op[0];
                    r_idx   <= '0;
                    r_count <= '0;
                end
            end else if (r_count != {CNT_W{1'b1}}) begin
                r_count <= r_count + CNT_W'(1);
            end

            case (r_state)
                S_LOAD: begin
                    r_idx <= r_idx + c_idx_w'(1);
                    // Read data trails its request by one cycle, so lane idx-1 lands now.
                    if (r_idx != '0) begin
                        r_tmp[w_prev_lane] <= bus.mem_rdata;
                    end
                end
                S_STORE: r_idx <= r_idx + c_idx_w'(1);
                S_ADD: begin
                    for (int i = 0; i < LANES; i++) begin
                        r_tmp[i] <= w_res[i];
                    end
                end
                S_WB: begin
                    for (int i = 0; i < LANES; i++) begin
                        r_vreg[r_vd][i] <= r_tmp[i];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vector_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_exec_unit
// Brief    : Self-checking bench: vector table, random ops against a
//            behavioural model, handshake/reset corners, wide-geometry instance.
// Revision : 1.0
// ============================================================================
module tb_vector_exec_unit;
    localparam int LANES = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    vector_exec_unit_if #(.DATA_W(8), .LANES(4), .NVREG(4), .ADDR_W(8), .CNT_W(16)) bus ();
    vector_exec_unit #(.DATA_W(8), .LANES(4), .NVREG(4), .ADDR_W(8), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    vector_exec_unit_if #(.DATA_W(16), .LANES(8), .NVREG(8), .ADDR_W(8), .CNT_W(16)) bus2 ();
    vector_exec_unit #(.DATA_W(16), .LANES(8), .NVREG(8), .ADDR_W(8), .CNT_W(16)) dut2 (
        .clock(clock), .reset(reset), .bus(bus2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memories: registered read, data valid the cycle after mem_rd
    logic [7:0]  mem  [256];
    logic [15:0] mem2 [256];
    logic        pre_we  = 1'b0;
    logic [7:0]  pre_addr, pre_data;
    logic        pre2_we = 1'b0;
    logic [7:0]  pre2_addr;
    logic [15:0] pre2_data;

    always @(posedge clock) begin
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    always @(posedge clock) begin
        if (bus2.mem_wr) mem2[bus2.mem_addr] <= bus2.mem_wdata;
        else if (pre2_we) mem2[pre2_addr] <= pre2_data;
        if (bus2.mem_rd) bus2.mem_rdata <= mem2[bus2.mem_addr];
    end

    // Reference model of the default instance
    logic [7:0] m_mem  [256];
    logic [7:0] m_vreg [4][4];

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        f = '0;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 4; i++)
                f[(r*4+i)*8 +: 8] = m_vreg[r][i];
        return f;
    endfunction

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clock);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clock);
        pre_we = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic poke2(input logic [7:0] a, input logic [15:0] d);
        @(negedge clock);
        pre2_we = 1'b1; pre2_addr = a; pre2_data = d;
        @(negedge clock);
        pre2_we = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [1:0] vd, input logic [1:0] vs,
                          input logic [7:0] base, output int lat);
        logic [7:0]   rd_a[$];
        int           rd_c[$];
        logic [7:0]   wr_a[$];
        logic [7:0]   wr_d[$];
        logic [127:0] flat_done;
        logic [7:0]   nv [4];
        bit           both;
        int           n, exp_lat, s;
        lat = -1; n = 0; both = 1'b0; flat_done = '0;
        exp_lat = (op == 2'b00) ? LANES + 3 : (op == 2'b01) ? LANES + 1 : 3;
        @(negedge clock);
        bus.start = 1'b1; bus.op = op; bus.vd = vd; bus.vs = vs; bus.base_addr = base;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.op = 2'($urandom); bus.vd = 2'($urandom); bus.vs = 2'($urandom);
        bus.base_addr = 8'($urandom);
        while (lat < 0 && n < 40) begin
            @(negedge clock);
            n++;
            if (bus.mem_rd && bus.mem_wr) both = 1'b1;
            if (bus.mem_rd) begin rd_a.push_back(bus.mem_addr); rd_c.push_back(n); end
            if (bus.mem_wr) begin wr_a.push_back(bus.mem_addr); wr_d.push_back(bus.mem_wdata); end
            if (bus.done) begin lat = n; flat_done = bus.vreg_flat; end
        end
        check("latency", lat, exp_lat);
        check("rd_wr_exclusive", both, 0);
        case (op)
            2'b00: begin
                check("load_rd_count", rd_a.size(), LANES);
                check("load_wr_count", wr_a.size(), 0);
                for (int i = 0; i < rd_a.size() && i < LANES; i++) begin
                    check($sformatf("load_addr%0d", i), rd_a[i], 8'(base + 8'(i)));
                    check($sformatf("load_cycle%0d", i), rd_c[i], i + 1);
                end
                for (int i = 0; i < 4; i++) m_vreg[vd][i] = m_mem[8'(base + 8'(i))];
            end
            2'b01: begin
                check("store_wr_count", wr_a.size(), LANES);
                check("store_rd_count", rd_a.size(), 0);
                for (int i = 0; i < wr_a.size() && i < LANES; i++) begin
                    check($sformatf("store_addr%0d", i), wr_a[i], 8'(base + 8'(i)));
                    check($sformatf("store_data%0d", i), wr_d[i], m_vreg[vs][i]);
                end
                for (int i = 0; i < 4; i++) m_mem[8'(base + 8'(i))] = m_vreg[vs][i];
            end
            default: begin
                check("add_no_mem", rd_a.size() + wr_a.size(), 0);
                for (int i = 0; i < 4; i++) begin
                    s = int'(m_vreg[vd][i]) + int'(m_vreg[vs][i]);
                    if (op == 2'b11 && s > 255) s = 255;
                    nv[i] = 8'(s % 256);
                end
                for (int i = 0; i < 4; i++) m_vreg[vd][i] = nv[i];
            end
        endcase
        check("flat_at_done", flat_done, model_flat());
        @(negedge clock);
        check("idle_busy", bus.busy, 0);
        check("idle_done", bus.done, 0);
        check("cycle_count", bus.cycle_count, exp_lat);
    endtask

    task automatic run2(input logic [1:0] op, input logic [2:0] vd, input logic [2:0] vs,
                        input logic [7:0] base, output int lat);
        int n;
        lat = -1; n = 0;
        @(negedge clock);
        bus2.start = 1'b1; bus2.op = op; bus2.vd = vd; bus2.vs = vs; bus2.base_addr = base;
        @(posedge clock);
        #1 bus2.start = 1'b0;
        while (lat < 0 && n < 60) begin
            @(negedge clock);
            n++;
            if (bus2.done) lat = n;
        end
        @(negedge clock);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  vd;
        logic [1:0]  vs;
        logic [7:0]  base;
        logic [31:0] exp_reg;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int lat, r, n, ndone, first;
        logic [7:0]   d;
        logic [127:0] exp2;
        logic [15:0]  w;

        tbl[0] = '{2'b00, 2'd2, 2'd0, 8'h10, 32'h44332211};
        tbl[1] = '{2'b00, 2'd1, 2'd0, 8'h20, 32'hDDCCBBAA};
        tbl[2] = '{2'b01, 2'd0, 2'd1, 8'hFE, 32'hDDCCBBAA};
        tbl[3] = '{2'b00, 2'd0, 2'd0, 8'h30, 32'h80FF0102};
        tbl[4] = '{2'b00, 2'd3, 2'd0, 8'h34, 32'h80020304};
        tbl[5] = '{2'b10, 2'd0, 2'd3, 8'h00, 32'h00010406};
        tbl[6] = '{2'b00, 2'd0, 2'd0, 8'h30, 32'h80FF0102};
        tbl[7] = '{2'b11, 2'd0, 2'd3, 8'h00, 32'hFFFF0406};
        tbl[8] = '{2'b10, 2'd3, 2'd3, 8'h00, 32'h00040608};
        tbl[9] = '{2'b11, 2'd0, 2'd0, 8'h00, 32'hFFFF080C};

        bus.start = 1'b0; bus.op = '0; bus.vd = '0; bus.vs = '0; bus.base_addr = '0;
        bus2.start = 1'b0; bus2.op = '0; bus2.vd = '0; bus2.vs = '0; bus2.base_addr = '0;
        for (int r2 = 0; r2 < 4; r2++)
            for (int i = 0; i < 4; i++) m_vreg[r2][i] = 8'h00;

        repeat (3) @(negedge clock);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_mem_wr", bus.mem_wr, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_cycle_count", bus.cycle_count, 0);
        check("rst_vreg_flat", bus.vreg_flat, 0);
        reset = 1'b0;

        for (int a = 0; a < 256; a++) begin
            case (a)
                8'h10: d = 8'h11;  8'h11: d = 8'h22;  8'h12: d = 8'h33;  8'h13: d = 8'h44;
                8'h20: d = 8'hAA;  8'h21: d = 8'hBB;  8'h22: d = 8'hCC;  8'h23: d = 8'hDD;
                8'h30: d = 8'h02;  8'h31: d = 8'h01;  8'h32: d = 8'hFF;  8'h33: d = 8'h80;
                8'h34: d = 8'h04;  8'h35: d = 8'h03;  8'h36: d = 8'h02;  8'h37: d = 8'h80;
                default: d = 8'($urandom);
            endcase
            poke(8'(a), d);
        end

        for (int k = 0; k < 10; k++) begin
            run_op(tbl[k].op, tbl[k].vd, tbl[k].vs, tbl[k].base, lat);
            r = (tbl[k].op == 2'b01) ? int'(tbl[k].vs) : int'(tbl[k].vd);
            check($sformatf("vec%0d_reg", k), bus.vreg_flat[r*32 +: 32], tbl[k].exp_reg);
        end
        check("store_wrap_mem", {mem[8'h01], mem[8'h00], mem[8'hFF], mem[8'hFE]}, 32'hDDCCBBAA);

        // start held high across a load, operands scrambled while busy
        @(negedge clock);
        bus.start = 1'b1; bus.op = 2'b00; bus.vd = 2'd2; bus.vs = 2'd0; bus.base_addr = 8'h10;
        @(posedge clock);
        #1;
        bus.op = 2'b01; bus.vd = 2'd0; bus.vs = 2'd2; bus.base_addr = 8'h40;
        ndone = 0; first = -1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            if (bus.done) begin ndone++; if (first < 0) first = c; end
        end
        check("hs_done_count", ndone, 1);
        check("hs_done_cycle", first, 7);
        for (int i = 0; i < 4; i++) m_vreg[2][i] = m_mem[8'h10 + 8'(i)];
        check("hs_flat", bus.vreg_flat, model_flat());
        @(negedge clock);
        check("hs_idle_busy", bus.busy, 0);
        @(negedge clock);
        check("hs_second_busy", bus.busy, 1);
        check("hs_second_addr", bus.mem_addr, 8'h40);
        check("hs_second_wr", bus.mem_wr, 1);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 40) begin @(negedge clock); n++; end
        check("hs_second_done", bus.done, 1);
        @(negedge clock);
        check("hs_second_count", bus.cycle_count, LANES + 1);
        for (int i = 0; i < 4; i++) m_mem[8'h40 + 8'(i)] = m_vreg[2][i];
        check("hs_second_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]},
              {m_vreg[2][3], m_vreg[2][2], m_vreg[2][1], m_vreg[2][0]});

        for (int k = 0; k < 40; k++)
            run_op(2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), lat);

        // wide geometry: load/store round trip
        exp2 = '0;
        for (int i = 0; i < 8; i++) begin
            w = 16'($urandom);
            exp2[i*16 +: 16] = w;
            poke2(8'h50 + 8'(i), w);
        end
        run2(2'b00, 3'd5, 3'd0, 8'h50, lat);
        check("wide_load_latency", lat, 11);
        check("wide_load_reg5", bus2.vreg_flat[5*128 +: 128], exp2);
        check("wide_reg0_untouched", bus2.vreg_flat[0 +: 128], 0);
        run2(2'b01, 3'd0, 3'd5, 8'hA0, lat);
        check("wide_store_latency", lat, 9);
        for (int i = 0; i < 8; i++)
            check($sformatf("wide_roundtrip%0d", i), mem2[8'hA0 + 8'(i)], exp2[i*16 +: 16]);

        // reset in the middle of a store
        @(negedge clock);
        bus.start = 1'b1; bus.op = 2'b01; bus.vs = 2'd1; bus.base_addr = 8'h60;
        @(posedge clock);
        #1 bus.start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        check("mid_store_wr", bus.mem_wr, 1);
        reset = 1'b1;
        #1;
        check("async_rst_mem_wr", bus.mem_wr, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_done", bus.done, 0);
        check("async_rst_flat", bus.vreg_flat, 0);
        check("async_rst_count", bus.cycle_count, 0);
        check("async_rst_addr", bus.mem_addr, 0);
        m_mem[8'h60] = m_vreg[1][0];
        m_mem[8'h61] = m_vreg[1][1];
        for (int r2 = 0; r2 < 4; r2++)
            for (int i = 0; i < 4; i++) m_vreg[r2][i] = 8'h00;
        @(negedge clock);
        reset = 1'b0;

        for (int k = 0; k < 12; k++)
            run_op(2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
